// File: rtl/div8_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Step counter must hold the values 0..width inclusive.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div8_seq_if.sv
// Operand/result handshake bundle for div8_seq.
interface div8_seq_if
  import div8_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             DZ;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output A, B, in_valid, out_ready,
    input  in_ready, Q, R, DZ, out_valid
  );

  modport slave (
    input  A, B, in_valid, out_ready,
    output in_ready, Q, R, DZ, out_valid
  );

endinterface

// File: rtl/div8_seq_div_step.sv
// One combinational restoring-division stage: shift in a dividend bit, trial-subtract.
module div_step
  import div8_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem_i[WIDTH-1:0], bit_i};
    diff    = {1'b0, shifted} - {2'b00, div_i};
    // A set top remainder bit means the shifted value exceeds any divisor.
    q_o     = ~diff[WIDTH+1] | rem_i[WIDTH];
    rem_o   = q_o ? diff[WIDTH:0] : shifted;
  end

endmodule

// File: rtl/div8_seq.sv
// Sequential unsigned divider: one restoring step per clock, valid/ready on both sides.
module div8_seq
  import div8_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  div8_seq_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_CALC = 2'(CALC);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   step_rem;
  logic             step_q;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .bit_i (dq_q[WIDTH-1]),
    .div_i (div_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Next-state and datapath update; dq doubles as dividend and quotient shift register.
  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    div_d   = div_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          dq_d    = bus.A;
          div_d   = bus.B;
          rem_d   = '0;
          cnt_d   = '0;
          dz_d    = (bus.B == '0);
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        rem_d = step_rem;
        dq_d  = {dq_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dq_q        <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dq_q        <= dq_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      dz_q        <= dz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Q         = dq_q;
  assign bus.R         = rem_q[WIDTH-1:0];
  assign bus.DZ        = dz_q;

endmodule
